// File: rtl/vital_alarm_monitor.sv
// Two-channel vital-sign threshold monitor with debounced, acknowledge-latched alarms.
// Optional per-channel alarm event counters when VITAL_MONITOR_STATS_EN is defined.
module vital_alarm_monitor #(
   parameter int CH0_LOW  = 40,
   parameter int CH0_HIGH = 150,
   parameter int CH1_LOW  = 35,
   parameter int CH1_HIGH = 39,
   parameter int DEBOUNCE = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sample_in,
   input  logic        sample_ch,
   input  logic        sample_valid,
   input  logic [1:0]  ack,
   output logic [1:0]  alarm,
   output logic [1:0]  alarm_high,
   output logic [7:0]  last_sample0,
   output logic [7:0]  last_sample1
`ifdef VITAL_MONITOR_STATS_EN
   ,
   output logic [15:0] event_count0,
   output logic [15:0] event_count1
`endif
);

   localparam logic [7:0] C0_LOW  = 8'(CH0_LOW);
   localparam logic [7:0] C0_HIGH = 8'(CH0_HIGH);
   localparam logic [7:0] C1_LOW  = 8'(CH1_LOW);
   localparam logic [7:0] C1_HIGH = 8'(CH1_HIGH);
   localparam logic [3:0] DEB     = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALARM   = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t     state_r     [2];
   state_t     state_nxt_s [2];
   logic [3:0] cnt_r       [2];
   logic [3:0] cnt_nxt_s   [2];
   logic [1:0] hit_s;
   logic [1:0] above_s;
   logic [1:0] below_s;
   logic [1:0] oor_s;
   logic [1:0] entering_s;
   logic [1:0] alarm_nxt_s;
   logic [1:0] alarm_high_nxt_s;

   // Classify the incoming sample against the thresholds of the channel it is tagged for.
   always_comb begin
      hit_s[0]   = sample_valid & ~sample_ch;
      hit_s[1]   = sample_valid & sample_ch;
      above_s[0] = (sample_in > C0_HIGH);
      below_s[0] = (sample_in < C0_LOW);
      above_s[1] = (sample_in > C1_HIGH);
      below_s[1] = (sample_in < C1_LOW);
      oor_s      = above_s | below_s;
   end

   // Per-channel state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 2; n++) begin
            state_r[n] <= ST_NORMAL;
            cnt_r[n]   <= 4'd0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            state_r[n] <= state_nxt_s[n];
            cnt_r[n]   <= cnt_nxt_s[n];
         end
      end
   end

   // Next-state logic; ack only matters in ALARM, and HOLD waits for a healthy sample.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         state_nxt_s[n] = state_r[n];
         case (state_r[n])
            ST_NORMAL: begin
               if (hit_s[n] && oor_s[n]) begin
                  state_nxt_s[n] = (DEB == 4'd1) ? ST_ALARM : ST_PENDING;
               end else begin
                  state_nxt_s[n] = ST_NORMAL;
               end
            end
            ST_PENDING: begin
               if (hit_s[n] && oor_s[n]) begin
                  state_nxt_s[n] = ((cnt_r[n] + 4'd1) == DEB) ? ST_ALARM : ST_PENDING;
               end else if (hit_s[n]) begin
                  state_nxt_s[n] = ST_NORMAL;
               end else begin
                  state_nxt_s[n] = ST_PENDING;
               end
            end
            ST_ALARM: begin
               if (ack[n]) begin
                  state_nxt_s[n] = (hit_s[n] && !oor_s[n]) ? ST_NORMAL : ST_HOLD;
               end else begin
                  state_nxt_s[n] = ST_ALARM;
               end
            end
            ST_HOLD: begin
               if (hit_s[n] && !oor_s[n]) begin
                  state_nxt_s[n] = ST_NORMAL;
               end else begin
                  state_nxt_s[n] = ST_HOLD;
               end
            end
            default: state_nxt_s[n] = ST_NORMAL;
         endcase
      end
   end

   // Counter and output next values derived from the current/next state pair.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         if (state_nxt_s[n] == ST_NORMAL) begin
            cnt_nxt_s[n] = 4'd0;
         end else if (((state_r[n] == ST_NORMAL) || (state_r[n] == ST_PENDING))
                      && hit_s[n] && oor_s[n]) begin
            cnt_nxt_s[n] = cnt_r[n] + 4'd1;
         end else begin
            cnt_nxt_s[n] = cnt_r[n];
         end
         entering_s[n]       = (state_nxt_s[n] == ST_ALARM) && (state_r[n] != ST_ALARM);
         alarm_nxt_s[n]      = (state_nxt_s[n] == ST_ALARM);
         alarm_high_nxt_s[n] = entering_s[n] ? above_s[n] : alarm_high[n];
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm        <= 2'b00;
         alarm_high   <= 2'b00;
         last_sample0 <= 8'd0;
         last_sample1 <= 8'd0;
      end else begin
         alarm      <= alarm_nxt_s;
         alarm_high <= alarm_high_nxt_s;
         if (hit_s[0]) begin
            last_sample0 <= sample_in;
         end else begin
            last_sample0 <= last_sample0;
         end
         if (hit_s[1]) begin
            last_sample1 <= sample_in;
         end else begin
            last_sample1 <= last_sample1;
         end
      end
   end

`ifdef VITAL_MONITOR_STATS_EN
   // Saturating count of alarm raises per channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_count0 <= 16'd0;
         event_count1 <= 16'd0;
      end else begin
         if (entering_s[0] && (event_count0 != 16'hFFFF)) begin
            event_count0 <= event_count0 + 16'd1;
         end else begin
            event_count0 <= event_count0;
         end
         if (entering_s[1] && (event_count1 != 16'hFFFF)) begin
            event_count1 <= event_count1 + 16'd1;
         end else begin
            event_count1 <= event_count1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vital_alarm_monitor.sv
// Self-checking bench for vital_alarm_monitor: directed test-plan steps followed by
// randomized traffic, all checked against a behavioural predictor of the alarm rules.
module tb_vital_alarm_monitor;

   localparam int LO  [2] = '{40, 35};
   localparam int HI  [2] = '{150, 39};
   localparam int DEB = 3;

   logic        clk;
   logic        rst_n;
   logic [7:0]  sample_in;
   logic        sample_ch;
   logic        sample_valid;
   logic [1:0]  ack;
   logic [1:0]  alarm;
   logic [1:0]  alarm_high;
   logic [7:0]  last_sample0;
   logic [7:0]  last_sample1;
`ifdef VITAL_MONITOR_STATS_EN
   logic [15:0] event_count0;
   logic [15:0] event_count1;
`endif

   int compared;
   int mismatched;

   // Predictor state: consecutive out-of-range run, alarm/acknowledged flags, latched direction.
   int         run    [2];
   bit         m_on   [2];
   bit         acked  [2];
   bit         m_high [2];
   logic [7:0] m_last [2];
   int         m_ev   [2];

   vital_alarm_monitor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .ack          (ack),
      .alarm        (alarm),
      .alarm_high   (alarm_high),
      .last_sample0 (last_sample0),
      .last_sample1 (last_sample1)
`ifdef VITAL_MONITOR_STATS_EN
      ,
      .event_count0 (event_count0),
      .event_count1 (event_count1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int n = 0; n < 2; n++) begin
         run[n] = 0; m_on[n] = 1'b0; acked[n] = 1'b0;
         m_high[n] = 1'b0; m_last[n] = 8'd0; m_ev[n] = 0;
      end
   endfunction

   function automatic void model_step(input bit v, input bit ch, input int s, input bit [1:0] a);
      for (int n = 0; n < 2; n++) begin
         bit hit;
         bit inr;
         hit = v && (int'(ch) == n);
         inr = (s >= LO[n]) && (s <= HI[n]);
         if (m_on[n]) begin
            if (a[n]) begin
               m_on[n] = 1'b0;
               if (hit && inr) begin acked[n] = 1'b0; run[n] = 0; end
               else acked[n] = 1'b1;
            end
         end else if (hit) begin
            if (acked[n]) begin
               if (inr) begin acked[n] = 1'b0; run[n] = 0; end
            end else if (!inr) begin
               run[n]++;
               if (run[n] >= DEB) begin
                  m_on[n] = 1'b1;
                  m_high[n] = (s > HI[n]);
                  if (m_ev[n] < 65535) m_ev[n]++;
               end
            end else begin
               run[n] = 0;
            end
         end
         if (hit) m_last[n] = 8'(s);
      end
   endfunction

   task automatic check_all(input string tag);
      logic [1:0] exp_alarm;
      logic [1:0] exp_high;
      exp_alarm = {m_on[1], m_on[0]};
      exp_high  = {m_high[1], m_high[0]};
      compared++;
      assert (alarm === exp_alarm) else begin
         mismatched++;
         $error("FAIL %s alarm observed=%b expected=%b", tag, alarm, exp_alarm);
      end
      compared++;
      assert (alarm_high === exp_high) else begin
         mismatched++;
         $error("FAIL %s alarm_high observed=%b expected=%b", tag, alarm_high, exp_high);
      end
      compared++;
      assert (last_sample0 === m_last[0]) else begin
         mismatched++;
         $error("FAIL %s last_sample0 observed=%0d expected=%0d", tag, last_sample0, m_last[0]);
      end
      compared++;
      assert (last_sample1 === m_last[1]) else begin
         mismatched++;
         $error("FAIL %s last_sample1 observed=%0d expected=%0d", tag, last_sample1, m_last[1]);
      end
`ifdef VITAL_MONITOR_STATS_EN
      compared++;
      assert (event_count0 === 16'(m_ev[0])) else begin
         mismatched++;
         $error("FAIL %s event_count0 observed=%0d expected=%0d", tag, event_count0, m_ev[0]);
      end
      compared++;
      assert (event_count1 === 16'(m_ev[1])) else begin
         mismatched++;
         $error("FAIL %s event_count1 observed=%0d expected=%0d", tag, event_count1, m_ev[1]);
      end
`endif
   endtask

   // One clock with the given inputs; the predictor advances on the same edge.
   task automatic cyc(input string tag, input bit v, input bit ch, input int s, input bit [1:0] a);
      sample_valid = v;
      sample_ch    = ch;
      sample_in    = 8'(s);
      ack          = a;
      @(posedge clk);
      model_step(v, ch, s, a);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sample_valid = 1'b0; sample_ch = 1'b0; sample_in = 8'd0; ack = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      do_reset();

      // Boundary values are in range.
      cyc("ch0_80",  1'b1, 1'b0, 80,  2'b00);
      cyc("ch0_150", 1'b1, 1'b0, 150, 2'b00);
      cyc("ch0_40",  1'b1, 1'b0, 40,  2'b00);

      // Debounce on three consecutive highs.
      cyc("ch0_160a", 1'b1, 1'b0, 160, 2'b00);
      cyc("ch0_160b", 1'b1, 1'b0, 160, 2'b00);
      cyc("ch0_160c", 1'b1, 1'b0, 160, 2'b00);
      cyc("idle",     1'b0, 1'b0, 0,   2'b00);
      cyc("ack_inr",  1'b1, 1'b0, 100, 2'b01);

      // An in-range sample clears the run.
      foreach (LO[k]) begin
         int hv;
         hv = (k == 0) ? 170 : 151;
         cyc("run_a",  1'b1, 1'b0, hv,  2'b00);
         cyc("run_b",  1'b1, 1'b0, hv,  2'b00);
         cyc("run_in", 1'b1, 1'b0, 100, 2'b00);
         cyc("run_c",  1'b1, 1'b0, hv,  2'b00);
         cyc("run_d",  1'b1, 1'b0, hv,  2'b00);
         cyc("run_clr",1'b1, 1'b0, 100, 2'b00);
      end

      // Channel 1 low alarm interleaved with healthy channel 0.
      for (int i = 0; i < 3; i++) begin
         cyc("ch1_34", 1'b1, 1'b1, 34, 2'b00);
         cyc("ch0_80i",1'b1, 1'b0, 80, 2'b00);
      end

      // Acknowledge while still abnormal, no re-raise, then a fresh alarm.
      for (int i = 0; i < 3; i++) cyc("ch0_raise", 1'b1, 1'b0, 160, 2'b00);
      cyc("ch0_ack", 1'b1, 1'b0, 160, 2'b01);
      for (int i = 0; i < 5; i++) cyc("ch0_hold", 1'b1, 1'b0, 160, 2'b00);
      cyc("ch0_rel", 1'b1, 1'b0, 100, 2'b00);
      for (int i = 0; i < 3; i++) cyc("ch0_again", 1'b1, 1'b0, 160, 2'b00);

      // Asynchronous reset in the middle of a cycle with both channels alarmed.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      assert (alarm === 2'b00) else begin
         mismatched++;
         $error("FAIL async_rst alarm observed=%b expected=%b", alarm, 2'b00);
      end
      model_reset();
      sample_valid = 1'b0; ack = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      cyc("post_rst_a", 1'b1, 1'b0, 200, 2'b00);
      cyc("post_rst_b", 1'b1, 1'b0, 10,  2'b00);

      // Randomized traffic biased toward the thresholds.
      for (int i = 0; i < 600; i++) begin
         int sel;
         int s;
         bit [1:0] a;
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       s = int'($urandom_range(0, 255));
            1:       s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(37, 43))
                                                     : int'($urandom_range(147, 153));
            default: s = int'($urandom_range(32, 42));
         endcase
         a[0] = ($urandom_range(0, 9) == 0);
         a[1] = ($urandom_range(0, 9) == 0);
         cyc("rand", ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), s, a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
